// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer (exception/interrupt entry, mret exit); TRAP_VECTORED_EN enables vectored interrupt redirect
module trap_ctrl #(
  parameter int DRAIN_MAX = 8,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        sw_irq,
  input  logic        mstatus_mie,
  input  logic        mie_meie,
  input  logic        mie_mtie,
  input  logic        mie_msie,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        retire_valid,
  input  logic [31:0] retire_pc,
  input  logic        mret,
  input  logic        pipe_idle,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        stall,
  output logic        flush,
  output logic        handle_trap,
  output logic        exit_trap,
  output logic [31:0] trap_epc,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        drain_timeout
);
  typedef enum logic [2:0] {IDLE, DRAIN, ENTER, REDIR, MRET} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic irq_pend, take_exc, take_irq, timeout;
  logic [3:0] irq_code;
  logic [31:0] base, vec_pc;
  assign irq_pend = mstatus_mie & ((ext_irq & mie_meie) | (sw_irq & mie_msie) | (timer_irq & mie_mtie));
  assign irq_code = (ext_irq & mie_meie) ? 4'd11 : (sw_irq & mie_msie) ? 4'd3 : 4'd7;
  assign take_exc = state == IDLE && exc_valid;
  assign take_irq = state == IDLE && !exc_valid && !mret && irq_pend && retire_valid;
  assign timeout  = state == DRAIN && !pipe_idle && cnt == CNT_W'(DRAIN_MAX - 1);
  assign base     = {mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign vec_pc = (mcause[31] && mtvec[1:0] == 2'b01) ? base + {26'b0, mcause[3:0], 2'b00} : base;
`else
  logic unused_mode;
  assign unused_mode = &mtvec[1:0];
  assign vec_pc = base;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = exc_valid ? DRAIN : mret ? MRET : take_irq ? DRAIN : IDLE;
      DRAIN:   state_nx = (pipe_idle || timeout) ? ENTER : DRAIN;
      ENTER:   state_nx = REDIR;
      default: state_nx = IDLE;
    endcase
  end
  assign stall          = state != IDLE;
  assign flush          = take_exc || take_irq;
  assign handle_trap    = state == ENTER;
  assign exit_trap      = state == MRET;
  assign redirect_valid = state == REDIR || state == MRET;
  assign redirect_pc    = state == REDIR ? vec_pc : state == MRET ? mepc : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      drain_timeout <= 1'b0;
      mcause        <= '0;
      mtval         <= '0;
      trap_epc      <= '0;
    end else begin
      state <= state_nx;
      cnt   <= state == DRAIN ? cnt + 1'b1 : '0;
      if (timeout) drain_timeout <= 1'b1;
      if (take_exc) begin
        mcause   <= {28'b0, exc_code};
        mtval    <= exc_tval;
        trap_epc <= exc_pc;
      end else if (take_irq) begin
        mcause   <= {1'b1, 27'b0, irq_code};
        mtval    <= '0;
        trap_epc <= retire_pc;
      end
    end
  end
endmodule
